// File: rtl/param_updown_counter.sv
// WIDTH-bit up/down counter with programmable terminal value, wrap/saturate mode,
// enable prescaler, terminal-count flag, wrap pulse and sticky overflow flag.
module param_updown_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DATA,
  input  logic             UP,
  input  logic             SATURATE,
  input  logic             CLEAR_OVF,
  output logic [WIDTH-1:0] COUNT,
  output logic             TERMINAL,
  output logic             WRAP,
  output logic             OVERFLOW
);

  localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MAX_COUNT);
  localparam bit               NEED_CLAMP = (MAX_COUNT < ((2 ** WIDTH) - 1));

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             step_c;
  logic [WIDTH-1:0] load_val_c;

  // Loads above the terminal value are clamped so the count never leaves 0..MAX_COUNT.
  generate
    if (NEED_CLAMP) begin : g_clamp
      assign load_val_c = (DATA > MAX_V) ? MAX_V : DATA;
    end else begin : g_no_clamp
      assign load_val_c = DATA;
    end
  endgenerate

  // Prescaler: one step per PRESCALE enabled, non-load cycles.
  generate
    if (PRESCALE > 1) begin : g_ps
      localparam int unsigned      PS_W    = $clog2(PRESCALE);
      localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
      logic [PS_W-1:0] ps_q, ps_d;

      always_comb begin
        ps_d   = ps_q;
        step_c = 1'b0;
        if (LOAD) begin
          ps_d = '0;
        end else if (ENABLE) begin
          if (ps_q == PS_LAST) begin
            ps_d   = '0;
            step_c = 1'b1;
          end else begin
            ps_d = ps_q + PS_W'(1);
          end
        end
      end

      always_ff @(posedge CLOCK) begin
        if (RESET) ps_q <= '0;
        else       ps_q <= ps_d;
      end
    end else begin : g_no_ps
      assign step_c = ENABLE & ~LOAD;
    end
  endgenerate

  // Next count selected by compare against the limits; no modulo arithmetic.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (CLEAR_OVF) ovf_d = 1'b0;
    if (LOAD) begin
      count_d = load_val_c;
    end else if (step_c) begin
      if (UP) begin
        if (count_q != MAX_V) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          ovf_d = 1'b1;
          if (!SATURATE) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          ovf_d = 1'b1;
          if (!SATURATE) begin
            count_d = MAX_V;
            wrap_d  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign COUNT    = count_q;
  assign WRAP     = wrap_q;
  assign OVERFLOW = ovf_q;
  assign TERMINAL = UP ? (count_q == MAX_V) : (count_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench for param_updown_counter: four instances (8-bit full range,
// modulo-10, prescale-3, 16-bit) share stimulus; expectations are queued per cycle.
module tb_param_updown_counter;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] cnt;
    logic        wrap;
    logic        ovf;
    logic        term;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0, en = 1'b0, ld = 1'b0, up = 1'b0, sat = 1'b0, clr = 1'b0;
  logic [15:0] data = '0;

  logic [7:0]  cnt_a, cnt_b, cnt_c;
  logic [15:0] cnt_d;
  logic        term_a, term_b, term_c, term_d;
  logic        wrap_a, wrap_b, wrap_c, wrap_d;
  logic        ovf_a, ovf_b, ovf_c, ovf_d;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_mis = 0;

  int dn_cnt [5] = '{2, 1, 0, 0, 0};
  int dn_ovf [5] = '{0, 0, 0, 1, 1};
  int ps_en  [7] = '{1, 1, 0, 1, 1, 1, 1};
  int ps_cnt [7] = '{0, 0, 0, 1, 1, 1, 2};

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(8), .MAX_COUNT(255), .PRESCALE(1)) u_full (
    .CLOCK(clk), .RESET(rst), .ENABLE(en), .LOAD(ld), .DATA(data[7:0]), .UP(up),
    .SATURATE(sat), .CLEAR_OVF(clr), .COUNT(cnt_a), .TERMINAL(term_a), .WRAP(wrap_a),
    .OVERFLOW(ovf_a));

  param_updown_counter #(.WIDTH(8), .MAX_COUNT(9), .PRESCALE(1)) u_mod10 (
    .CLOCK(clk), .RESET(rst), .ENABLE(en), .LOAD(ld), .DATA(data[7:0]), .UP(up),
    .SATURATE(sat), .CLEAR_OVF(clr), .COUNT(cnt_b), .TERMINAL(term_b), .WRAP(wrap_b),
    .OVERFLOW(ovf_b));

  param_updown_counter #(.WIDTH(8), .MAX_COUNT(255), .PRESCALE(3)) u_ps3 (
    .CLOCK(clk), .RESET(rst), .ENABLE(en), .LOAD(ld), .DATA(data[7:0]), .UP(up),
    .SATURATE(sat), .CLEAR_OVF(clr), .COUNT(cnt_c), .TERMINAL(term_c), .WRAP(wrap_c),
    .OVERFLOW(ovf_c));

  param_updown_counter #(.WIDTH(16), .MAX_COUNT(65535), .PRESCALE(1)) u_wide (
    .CLOCK(clk), .RESET(rst), .ENABLE(en), .LOAD(ld), .DATA(data), .UP(up),
    .SATURATE(sat), .CLEAR_OVF(clr), .COUNT(cnt_d), .TERMINAL(term_d), .WRAP(wrap_d),
    .OVERFLOW(ovf_d));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic l, input logic [15:0] d,
                       input logic u, input logic s, input logic c);
    rst = r; en = e; ld = l; data = d; up = u; sat = s; clr = c;
  endtask

  task automatic push_exp(input string tag, input int sel, input int cnt,
                          input logic w, input logic o, input logic t);
    exp_t e;
    e.sel  = 2'(sel);
    e.cnt  = 16'(cnt);
    e.wrap = w;
    e.ovf  = o;
    e.term = t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Advance one edge, then retire every expectation queued for it.
  task automatic tick();
    exp_t        e;
    string       tag;
    logic [15:0] oc;
    logic        ow, oo, ot;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      case (e.sel)
        2'd0:    begin oc = 16'(cnt_a); ow = wrap_a; oo = ovf_a; ot = term_a; end
        2'd1:    begin oc = 16'(cnt_b); ow = wrap_b; oo = ovf_b; ot = term_b; end
        2'd2:    begin oc = 16'(cnt_c); ow = wrap_c; oo = ovf_c; ot = term_c; end
        default: begin oc = cnt_d;      ow = wrap_d; oo = ovf_d; ot = term_d; end
      endcase
      check_val({tag, ".count"},    32'(oc), 32'(e.cnt));
      check_val({tag, ".wrap"},     32'(ow), 32'(e.wrap));
      check_val({tag, ".overflow"}, 32'(oo), 32'(e.ovf));
      check_val({tag, ".terminal"}, 32'(ot), 32'(e.term));
    end
  endtask

  initial begin
    // Reset with ENABLE held, then first steps
    drive(1, 1, 0, 0, 1, 0, 0); push_exp("rst_up", 0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0, 0); push_exp("rst_dn", 0, 0, 0, 0, 1); tick();
    drive(0, 1, 0, 0, 1, 0, 0); push_exp("first_step", 0, 1, 0, 0, 0); tick();
    push_exp("second_step", 0, 2, 0, 0, 0); tick();

    // Modulo-10 wrap
    drive(1, 0, 0, 0, 1, 0, 0); push_exp("mod_rst", 1, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      push_exp("mod_wrap", 1, i % 10, logic'(i == 10), logic'(i >= 10), logic'((i % 10) == 9));
      tick();
    end

    // Down count with saturation and overflow clear
    drive(1, 0, 0, 0, 0, 1, 0); push_exp("dn_rst", 1, 0, 0, 0, 1); tick();
    drive(0, 0, 1, 3, 0, 1, 0); push_exp("dn_load", 1, 3, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      push_exp("dn_sat", 1, dn_cnt[i], 0, logic'(dn_ovf[i]), logic'(dn_cnt[i] == 0));
      tick();
    end
    drive(0, 0, 0, 0, 0, 1, 1); push_exp("ovf_clear", 1, 0, 0, 0, 1); tick();
    drive(0, 1, 0, 0, 0, 1, 1); push_exp("ovf_set_wins", 1, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 0, 1, 0); push_exp("ovf_sticky", 1, 0, 0, 1, 1); tick();

    // Load clamp, priorities and non-power-of-two down wrap
    drive(0, 0, 1, 200, 1, 0, 0);
    push_exp("load_clamp", 1, 9, 0, 1, 1);
    push_exp("load_noclamp", 0, 200, 0, 1, 0);
    tick();
    drive(0, 1, 1, 4, 1, 0, 0); push_exp("load_beats_en", 1, 4, 0, 1, 0); tick();
    drive(1, 0, 1, 7, 1, 0, 0); push_exp("rst_beats_load", 1, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0); push_exp("down_wrap", 1, 9, 1, 1, 0); tick();
    push_exp("down_after_wrap", 1, 8, 0, 1, 0); tick();

    // Prescale by 3, load and reset discard partial prescale
    drive(1, 0, 0, 0, 1, 0, 0); push_exp("ps_rst", 2, 0, 0, 0, 0); tick();
    for (int i = 0; i < 7; i++) begin
      drive(0, logic'(ps_en[i]), 0, 0, 1, 0, 0);
      push_exp("ps_pattern", 2, ps_cnt[i], 0, 0, 0);
      tick();
    end
    drive(0, 1, 0, 0, 1, 0, 0);  push_exp("ps_partial", 2, 2, 0, 0, 0); tick();
    drive(0, 1, 1, 50, 1, 0, 0); push_exp("ps_load", 2, 50, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 1, 0, 0);
    push_exp("ps_after_load1", 2, 50, 0, 0, 0); tick();
    push_exp("ps_after_load2", 2, 50, 0, 0, 0); tick();
    push_exp("ps_after_load3", 2, 51, 0, 0, 0); tick();
    push_exp("ps_partial2", 2, 51, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 1, 0, 0); push_exp("ps_mid_rst", 2, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 1, 0, 0);
    push_exp("ps_after_rst1", 2, 0, 0, 0, 0); tick();
    push_exp("ps_after_rst2", 2, 0, 0, 0, 0); tick();
    push_exp("ps_after_rst3", 2, 1, 0, 0, 0); tick();

    // 16-bit instance: wrap both directions, then saturate at top
    drive(1, 0, 0, 0, 0, 0, 0); push_exp("w_rst", 3, 0, 0, 0, 1); tick();
    drive(0, 1, 0, 0, 0, 0, 0); push_exp("w_down_wrap", 3, 65535, 1, 1, 0); tick();
    drive(0, 1, 0, 0, 1, 0, 0); push_exp("w_up_wrap", 3, 0, 1, 1, 0); tick();
    push_exp("w_up_step", 3, 1, 0, 1, 0); tick();
    drive(0, 0, 1, 16'hFFFF, 1, 1, 0); push_exp("w_load_top", 3, 65535, 0, 1, 1); tick();
    drive(0, 1, 0, 0, 1, 1, 0); push_exp("w_sat_top", 3, 65535, 0, 1, 1); tick();

    drive(0, 0, 0, 0, 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
